rst_sequencer: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 18 +
 rtl/rst_seq_sync.sv | 23 ++
 rtl/rst_sequencer.sv | 155 +++++++++++++++
 tb/tb_rst_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared state encoding and counter widths for the staged reset sequencer.
package rst_seq_pkg;

   typedef enum logic [2:0] {
      S_WAIT_LOCK = 3'd0,
      S_HOLD      = 3'd1,
      S_REL       = 3'd2,
      S_WAIT_ACK  = 3'd3,
      S_DLY       = 3'd4,
      S_DONE      = 3'd5,
      S_FAULT     = 3'd6
   } rst_seq_state_t;

   localparam int TO_W    = 16;
   localparam int DLY_W   = 8;
   localparam int RETRY_W = 4;

endpackage

// File: rtl/rst_seq_sync.sv
// Parameterised-width 2-flop synchronizer; both stages reset to 0.
module rst_seq_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset controller: releases stage resets in order after PLL lock, one per ack.
// Define RST_SEQ_SYNC_EN to pass locked/stage_ack through 2-flop synchronizers.
module rst_sequencer
   import rst_seq_pkg::*;
#(
   parameter int NUM_STAGES  = 4,
   parameter int HOLD_CYC    = 10,
   parameter int STAGE_DLY   = 8,
   parameter int ACK_TIMEOUT = 1000,
   parameter int MAX_RETRY   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  locked,
   input  logic                  sw_rst_req,
   input  logic [NUM_STAGES-1:0] stage_ack,
   output logic [NUM_STAGES-1:0] stage_rst,
   output logic                  all_ready,
   output logic                  busy,
   output logic                  fault,
   output logic [3:0]            retry_cnt
);

   localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [NUM_STAGES-1:0] ALL1 = '1;
   localparam logic [DLY_W-1:0] HOLD_LAST = DLY_W'(HOLD_CYC - 1);
   localparam logic [DLY_W-1:0] DLY_LAST  = (STAGE_DLY > 0) ? DLY_W'(STAGE_DLY - 1) : '0;
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
   localparam logic [KW-1:0]    K_LAST    = KW'(NUM_STAGES - 1);

   logic                  locked_s;
   logic [NUM_STAGES-1:0] ack_s;

`ifdef RST_SEQ_SYNC_EN
   rst_seq_sync #(.W(NUM_STAGES + 1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   ({stage_ack, locked}),
      .q   ({ack_s, locked_s})
   );
`else
   assign locked_s = locked;
   assign ack_s    = stage_ack;
`endif

   rst_seq_state_t        state, nxt;
   logic [DLY_W-1:0]      dly_cnt, dly_nxt;
   logic [TO_W-1:0]       to_cnt, to_nxt;
   logic [KW-1:0]         k, k_nxt;
   logic [RETRY_W-1:0]    retry_nxt;
   logic [NUM_STAGES-1:0] stage_rst_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_WAIT_LOCK;
         dly_cnt   <= '0;
         to_cnt    <= '0;
         k         <= '0;
         retry_cnt <= '0;
         stage_rst <= '1;
         all_ready <= 1'b0;
         busy      <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= nxt;
         dly_cnt   <= dly_nxt;
         to_cnt    <= to_nxt;
         k         <= k_nxt;
         retry_cnt <= retry_nxt;
         stage_rst <= stage_rst_nxt;
         all_ready <= (nxt == S_DONE);
         busy      <= (nxt inside {S_HOLD, S_REL, S_WAIT_ACK, S_DLY});
         fault     <= (nxt == S_FAULT);
      end
   end

   always_comb begin
      nxt       = state;
      dly_nxt   = dly_cnt;
      to_nxt    = to_cnt;
      k_nxt     = k;
      retry_nxt = retry_cnt;
      // Lock loss outranks everything, then software restart.
      if (!locked_s) begin
         nxt       = S_WAIT_LOCK;
         dly_nxt   = '0;
         to_nxt    = '0;
         k_nxt     = '0;
         retry_nxt = '0;
      end else if (sw_rst_req && state != S_WAIT_LOCK) begin
         nxt       = S_HOLD;
         dly_nxt   = '0;
         to_nxt    = '0;
         k_nxt     = '0;
         retry_nxt = '0;
      end else begin
         case (state)
            S_WAIT_LOCK: begin
               nxt     = S_HOLD;
               dly_nxt = '0;
               k_nxt   = '0;
            end
            S_HOLD: begin
               if (dly_cnt >= HOLD_LAST) begin
                  nxt     = S_REL;
                  dly_nxt = '0;
                  k_nxt   = '0;
               end else if (dly_cnt != '1) begin
                  dly_nxt = dly_cnt + DLY_W'(1);
               end
            end
            S_REL: begin
               nxt    = S_WAIT_ACK;
               to_nxt = '0;
            end
            S_WAIT_ACK: begin
               // Ack is checked before the timeout so a same-cycle ack wins.
               if (ack_s[k]) begin
                  nxt     = (k == K_LAST) ? S_DONE : S_DLY;
                  dly_nxt = '0;
                  if (k == K_LAST) retry_nxt = '0;
               end else if (to_cnt >= TO_LAST) begin
                  if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                     nxt       = S_HOLD;
                     dly_nxt   = '0;
                     k_nxt     = '0;
                     retry_nxt = retry_cnt + RETRY_W'(1);
                  end else begin
                     nxt = S_FAULT;
                  end
               end else if (to_cnt != '1) begin
                  to_nxt = to_cnt + TO_W'(1);
               end
            end
            S_DLY: begin
               if (dly_cnt >= DLY_LAST) begin
                  nxt     = S_REL;
                  dly_nxt = '0;
                  k_nxt   = k + KW'(1);
               end else if (dly_cnt != '1) begin
                  dly_nxt = dly_cnt + DLY_W'(1);
               end
            end
            default: ;
         endcase
      end

      case (nxt)
         S_REL, S_WAIT_ACK, S_DLY: stage_rst_nxt = ALL1 << (int'(k_nxt) + 1);
         S_DONE:                   stage_rst_nxt = '0;
         default:                  stage_rst_nxt = ALL1;
      endcase
   end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed-sequence bench for rst_sequencer with randomized ack delays; expected
// outputs come from the per-phase cycle budgets of the sequence.
module tb_rst_sequencer;

   localparam int NS = 3;
   localparam int HC = 10;
   localparam int SD = 4;
   localparam int AT = 20;
   localparam int MR = 2;
   localparam int NEVER = 999;

   logic          clk = 1'b0;
   logic          rst;
   logic          locked;
   logic          sw_rst_req;
   logic [NS-1:0] stage_ack;
   logic [NS-1:0] stage_rst;
   logic          all_ready;
   logic          busy;
   logic          fault;
   logic [3:0]    retry_cnt;

   rst_sequencer #(
      .NUM_STAGES (NS),
      .HOLD_CYC   (HC),
      .STAGE_DLY  (SD),
      .ACK_TIMEOUT(AT),
      .MAX_RETRY  (MR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .locked    (locked),
      .sw_rst_req(sw_rst_req),
      .stage_ack (stage_ack),
      .stage_rst (stage_rst),
      .all_ready (all_ready),
      .busy      (busy),
      .fault     (fault),
      .retry_cnt (retry_cnt)
   );

   always #5 clk = ~clk;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic          cur_locked;
   logic [NS-1:0] cur_ack;
   logic          cur_sw;
   int            cur_retry;
   logic [9:0]    obs;

   assign obs = {stage_rst, busy, all_ready, fault, retry_cnt};

   task automatic chk(input string tag, input logic [9:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed rst/busy/rdy/flt/retry=%b expected %b", tag, obs, exp);
      end
   endtask

   // One entry per cycle: check the outputs for this cycle, then drive its inputs.
   task automatic seg(input string tag, input int n, input logic [2:0] r,
                      input logic b, input logic rd, input logic f);
      for (int i = 0; i < n; i++) begin
         chk(tag, {r, b, rd, f, 4'(cur_retry)});
         locked     = cur_locked;
         stage_ack  = cur_ack;
         sw_rst_req = cur_sw;
         cur_sw     = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   // d = cycle (relative to release) on which the ack rises; NEVER = no ack.
   task automatic stage(input int i, input int d, output bit to);
      logic [2:0] rel;
      rel = 3'b111 << (i + 1);
      to  = 1'b0;
      if (d == 0) cur_ack[i] = 1'b1;
      seg("rel", 1, rel, 1'b1, 1'b0, 1'b0);
      if (cur_ack[i]) begin
         seg("wait_ack_early", 1, rel, 1'b1, 1'b0, 1'b0);
      end else if (d > AT) begin
         seg("wait_ack_timeout", AT, rel, 1'b1, 1'b0, 1'b0);
         to = 1'b1;
      end else begin
         seg("wait_ack", d - 1, rel, 1'b1, 1'b0, 1'b0);
         cur_ack[i] = 1'b1;
         seg("wait_ack_hit", 1, rel, 1'b1, 1'b0, 1'b0);
      end
      if (!to && i < NS - 1) seg("dly", SD, rel, 1'b1, 1'b0, 1'b0);
   endtask

   // Full sequence from the first HOLD cycle until DONE or FAULT entry.
   task automatic sequence_run(input int d0, input int d1, input int d2, output bit faulted);
      int d[NS];
      bit to;
      d[0] = d0;
      d[1] = d1;
      d[2] = d2;
      faulted = 1'b0;
      for (int attempt = 0; attempt <= MR; attempt++) begin
         seg("hold", HC, 3'b111, 1'b1, 1'b0, 1'b0);
         to = 1'b0;
         for (int i = 0; i < NS; i++) begin
            stage(i, d[i], to);
            if (to) break;
         end
         if (!to) begin
            cur_retry = 0;
            return;
         end
         if (cur_retry < MR) cur_retry++;
         else begin
            faulted = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      bit f;
      bit to;
      rst        = 1'b1;
      locked     = 1'b0;
      sw_rst_req = 1'b0;
      stage_ack  = '0;
      cur_locked = 1'b0;
      cur_ack    = '0;
      cur_sw     = 1'b0;
      cur_retry  = 0;

      @(posedge clk);
      #1;
      chk("reset_values", {3'b111, 1'b0, 1'b0, 1'b0, 4'd0});
      @(posedge clk);
      #1;
      rst = 1'b0;

      // sw_rst_req while waiting for lock has no effect
      cur_sw = 1'b1;
      seg("wait_lock_sw", 1, 3'b111, 1'b0, 1'b0, 1'b0);
      seg("wait_lock", 3, 3'b111, 1'b0, 1'b0, 1'b0);

      // Normal sequence
      cur_locked = 1'b1;
      seg("lock_rise", 1, 3'b111, 1'b0, 1'b0, 1'b0);
      sequence_run($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), f);
      seg("done", 3, 3'b000, 1'b0, 1'b1, 1'b0);
      cur_ack[0] = 1'b0;
      seg("done_ack_drop", 3, 3'b000, 1'b0, 1'b1, 1'b0);

      // Restart from DONE; acks of unreleased stages already high are ignored
      cur_sw  = 1'b1;
      cur_ack = 3'b110;
      seg("sw_from_done", 1, 3'b000, 1'b0, 1'b1, 1'b0);
      sequence_run($urandom_range(1, 5), $urandom_range(0, 5), $urandom_range(0, 5), f);
      seg("done2", 2, 3'b000, 1'b0, 1'b1, 1'b0);

      // Stage 1 never acks: two retries then FAULT
      cur_sw  = 1'b1;
      cur_ack = '0;
      seg("sw_from_done", 1, 3'b000, 1'b0, 1'b1, 1'b0);
      sequence_run($urandom_range(0, 5), NEVER, 1, f);
      seg("fault", 4, 3'b111, 1'b0, 1'b0, 1'b1);

      // Restart from FAULT
      cur_sw  = 1'b1;
      cur_ack = '0;
      seg("sw_from_fault", 1, 3'b111, 1'b0, 1'b0, 1'b1);
      cur_retry = 0;
      sequence_run($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), f);
      seg("done3", 2, 3'b000, 1'b0, 1'b1, 1'b0);

      // Lock lost in stage-1 WAIT_ACK together with sw_rst_req: lock wins
      cur_sw  = 1'b1;
      cur_ack = '0;
      seg("sw_from_done", 1, 3'b000, 1'b0, 1'b1, 1'b0);
      seg("hold", HC, 3'b111, 1'b1, 1'b0, 1'b0);
      stage(0, $urandom_range(1, 5), to);
      seg("rel1", 1, 3'b100, 1'b1, 1'b0, 1'b0);
      seg("wait_ack1", 2, 3'b100, 1'b1, 1'b0, 1'b0);
      cur_locked = 1'b0;
      cur_sw     = 1'b1;
      seg("wait_ack1_drop", 1, 3'b100, 1'b1, 1'b0, 1'b0);
      cur_ack = '0;
      seg("lock_lost", 4, 3'b111, 1'b0, 1'b0, 1'b0);

      // Relock; stage-0 ack lands on the last WAIT_ACK cycle before timeout
      cur_locked = 1'b1;
      seg("relock", 1, 3'b111, 1'b0, 1'b0, 1'b0);
      sequence_run(AT, $urandom_range(0, 5), $urandom_range(0, 5), f);
      seg("done4", 2, 3'b000, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset while in DLY
      cur_sw  = 1'b1;
      cur_ack = '0;
      seg("sw_from_done", 1, 3'b000, 1'b0, 1'b1, 1'b0);
      seg("hold", HC, 3'b111, 1'b1, 1'b0, 1'b0);
      seg("rel0", 1, 3'b110, 1'b1, 1'b0, 1'b0);
      cur_ack[0] = 1'b1;
      seg("wait_ack0", 1, 3'b110, 1'b1, 1'b0, 1'b0);
      seg("dly0", 2, 3'b110, 1'b1, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_immediate", {3'b111, 1'b0, 1'b0, 1'b0, 4'd0});
      @(posedge clk);
      #1;
      chk("async_rst_held", {3'b111, 1'b0, 1'b0, 1'b0, 4'd0});
      rst       = 1'b0;
      cur_ack   = '0;
      cur_retry = 0;
      seg("post_rst_wait_lock", 1, 3'b111, 1'b0, 1'b0, 1'b0);
      sequence_run($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), f);
      seg("done5", 2, 3'b000, 1'b0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
